// File: rtl/snn_seq_pkg.sv
// Shared types and window-length selection for the SNN layer sequencer.
// Default sizing macros are supplied here when the surrounding build does not define them.
`ifndef SNN_NUM_SPIKES
`define SNN_NUM_SPIKES 8
`endif
`ifndef SNN_LOG_TIME_PERIOD
`define SNN_LOG_TIME_PERIOD 5
`endif
`ifndef SNN_TIME_PERIOD
`define SNN_TIME_PERIOD 24
`endif
`ifndef SNN_TESTING_PERIOD
`define SNN_TESTING_PERIOD 8
`endif
`ifndef SNN_LOG_NEURONS_PER_LAYER
`define SNN_LOG_NEURONS_PER_LAYER 3
`endif

package snn_seq_pkg;

  localparam int unsigned DEF_NUM_SPIKES = `SNN_NUM_SPIKES;
  localparam int unsigned DEF_TIME_W     = `SNN_LOG_TIME_PERIOD + 1;

  localparam logic MODE_TRAIN = 1'b1;
  localparam logic MODE_TEST  = 1'b0;

  typedef enum logic [1:0] {IDLE, RUN, EMIT} seq_state_t;

  typedef logic [DEF_NUM_SPIKES-1:0][DEF_TIME_W-1:0] spike_vec_t;

  // Window length P for the latched mode.
  function automatic int unsigned window_len(input logic train,
                                             input int unsigned train_len,
                                             input int unsigned test_len);
    return (train == MODE_TRAIN) ? train_len : test_len;
  endfunction

endpackage

// File: rtl/snn_layer_sequencer_step_counter.sv
// Saturating step counter for one time window; last flags step limit-1.
module step_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         last
);

  assign last = (count == (limit - W'(1)));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !last) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/snn_layer_sequencer.sv
// Time-base and sample-flow sequencer for one clocked-STDP layer instance.
module snn_layer_sequencer
  import snn_seq_pkg::*;
#(
  parameter int NUM_SPIKES     = `SNN_NUM_SPIKES,
  parameter int TIME_W         = `SNN_LOG_TIME_PERIOD + 1,
  parameter int NEURON_W       = `SNN_LOG_NEURONS_PER_LAYER + 1,
  parameter int TIME_PERIOD    = `SNN_TIME_PERIOD,
  parameter int TESTING_PERIOD = `SNN_TESTING_PERIOD
) (
  input  logic                               clk,
  input  logic                               rst_l,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_train,
  input  logic [NUM_SPIKES-1:0][TIME_W-1:0]  in_spike_times,
  output logic [NUM_SPIKES-1:0][TIME_W-1:0]  layer_spike_times,
  output logic                               layer_training,
  output logic [TIME_W-1:0]                  layer_time_val,
  output logic                               layer_epoch_start,
  input  logic [NEURON_W-1:0]                layer_winning_neuron,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [NEURON_W-1:0]                res_neuron,
  output logic [15:0]                        sample_count,
  output logic                               busy
);

  seq_state_t                        state, state_next;
  logic [NUM_SPIKES-1:0][TIME_W-1:0] spikes_q;
  logic                              train_q;
  logic [NEURON_W-1:0]               neuron_q;
  logic [15:0]                       sample_cnt_q;
  logic [TIME_W-1:0]                 step;
  logic [TIME_W-1:0]                 limit;
  logic                              step_last;
  logic                              accept;
  logic                              window_end;

  assign accept     = (state == IDLE) && in_valid;
  assign window_end = (state == RUN) && step_last;
  assign limit      = TIME_W'(window_len(train_q, TIME_PERIOD, TESTING_PERIOD));

  step_counter #(.W(TIME_W)) u_step (
    .clk    (clk),
    .rst_l  (rst_l),
    .clear  (accept),
    .enable (state == RUN),
    .limit  (limit),
    .count  (step),
    .last   (step_last)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: defaulting state_next before the case keeps this block free of inferred latches.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (step_last) state_next = (train_q == MODE_TRAIN) ? IDLE : EMIT;
      EMIT:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      spikes_q     <= '0;
      train_q      <= 1'b0;
      neuron_q     <= '0;
      sample_cnt_q <= '0;
    end else begin
      if (accept) begin
        spikes_q <= in_spike_times;
        train_q  <= in_train;
      end
      if (window_end) begin
        sample_cnt_q <= sample_cnt_q + 16'd1;
        if (train_q == MODE_TEST) neuron_q <= layer_winning_neuron;
      end
    end
  end

  // The counter parks at P-1 after a window, so time_val is gated to 0 outside RUN.
  assign layer_time_val    = (state == RUN) ? step : '0;
  assign layer_epoch_start = (state == RUN) && (step == '0);
  assign layer_spike_times = spikes_q;
  assign layer_training    = train_q;
  assign in_ready          = (state == IDLE);
  assign res_valid         = (state == EMIT);
  assign res_neuron        = neuron_q;
  assign sample_count      = sample_cnt_q;
  assign busy              = (state != IDLE);

endmodule

// File: tb/tb_snn_layer_sequencer.sv
// Scoreboard bench for snn_layer_sequencer: directed samples, result queue checked by a monitor.
module tb_snn_layer_sequencer;
  import snn_seq_pkg::*;

  localparam int NS  = 8;
  localparam int TW  = 6;
  localparam int NW  = 4;
  localparam int TP  = 24;
  localparam int TSP = 8;

  typedef struct {
    logic [NW-1:0] neuron;
    logic [15:0]   count;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_l = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_train = 1'b0;
  spike_vec_t       in_spike_times = '0;
  spike_vec_t       layer_spike_times;
  logic             layer_training;
  logic [TW-1:0]    layer_time_val;
  logic             layer_epoch_start;
  logic [NW-1:0]    layer_winning_neuron;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [NW-1:0]    res_neuron;
  logic [15:0]      sample_count;
  logic             busy;

  logic [NW-1:0]    model_winner = '0;
  int               n_checks = 0;
  int               n_pass = 0;
  int               cyc = 0;
  exp_t             exp_q[$];
  spike_vec_t       spikes_a, spikes_b;

  snn_layer_sequencer #(
    .NUM_SPIKES(NS), .TIME_W(TW), .NEURON_W(NW),
    .TIME_PERIOD(TP), .TESTING_PERIOD(TSP)
  ) dut (
    .clk                  (clk),
    .rst_l                (rst_l),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_train             (in_train),
    .in_spike_times       (in_spike_times),
    .layer_spike_times    (layer_spike_times),
    .layer_training       (layer_training),
    .layer_time_val       (layer_time_val),
    .layer_epoch_start    (layer_epoch_start),
    .layer_winning_neuron (layer_winning_neuron),
    .res_valid            (res_valid),
    .res_ready            (res_ready),
    .res_neuron           (res_neuron),
    .sample_count         (sample_count),
    .busy                 (busy)
  );

  // Layer stand-in: the chosen winner appears only at step 7, a filler index elsewhere.
  assign layer_winning_neuron = (layer_time_val == TW'(7)) ? model_winner : NW'(2);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard monitor: compares each taken result against the oldest expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_l && res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_result: got neuron 0x%0h, expected no result", res_neuron);
        end else begin
          e = exp_q.pop_front();
          check("res_neuron", 64'(res_neuron), 64'(e.neuron));
          check("res_sample_count", 64'(sample_count), 64'(e.count));
        end
      end
    end
  end

  // Offer a sample from IDLE; returns at the negedge of cycle E+1 with scrambled inputs.
  task automatic offer(input logic train, input spike_vec_t spikes);
    int waited = 0;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL offer_timeout: in_ready stayed 0, expected 1");
    end
    in_valid       = 1'b1;
    in_train       = train;
    in_spike_times = spikes;
    @(negedge clk);
    in_valid       = 1'b0;
    in_train       = ~train;
    in_spike_times = ~spikes;
  endtask

  // Check n steps of a running window, starting at step 0.
  task automatic check_window(input int n, input spike_vec_t spikes, input logic train);
    for (int k = 0; k < n; k++) begin
      check($sformatf("time_val_step%0d", k), 64'(layer_time_val), 64'(k));
      check($sformatf("epoch_start_step%0d", k), 64'(layer_epoch_start), 64'(k == 0));
      check("in_ready_run", 64'(in_ready), 64'd0);
      check("res_valid_run", 64'(res_valid), 64'd0);
      if (k == 1) begin
        check("latched_spikes", 64'(layer_spike_times), 64'(spikes));
        check("latched_mode", 64'(layer_training), 64'(train));
      end
      @(negedge clk);
    end
  endtask

  initial begin : stimulus
    int acc[3];
    int n_acc;
    int waited;
    logic [TW-1:0] vals_a[NS] = '{3, 0, 7, 12, 1, 23, 5, 9};
    for (int i = 0; i < NS; i++) begin
      spikes_a[i] = vals_a[i];
      spikes_b[i] = TW'(2 * i + 1);
    end

    // Reset state
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_time_val", 64'(layer_time_val), 64'd0);
    check("rst_spikes", 64'(layer_spike_times), 64'd0);
    check("rst_sample_count", 64'(sample_count), 64'd0);
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_epoch", 64'(layer_epoch_start), 64'd0);
    check("post_rst_res_neuron", 64'(res_neuron), 64'd0);

    // Single train sample: 24 steps, back in IDLE at E+25
    offer(1'b1, spikes_a);
    check_window(TP, spikes_a, 1'b1);
    check("train_in_ready_back", 64'(in_ready), 64'd1);
    check("train_time_val_idle", 64'(layer_time_val), 64'd0);
    check("train_sample_count", 64'(sample_count), 64'd1);
    check("train_spikes_held", 64'(layer_spike_times), 64'(spikes_a));

    // Test sample with 4 cycles of result backpressure
    res_ready    = 1'b0;
    model_winner = NW'(5);
    exp_q.push_back('{neuron: NW'(5), count: 16'd2});
    offer(1'b0, spikes_b);
    check_window(TSP, spikes_b, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("emit_res_valid", 64'(res_valid), 64'd1);
      check("emit_res_neuron", 64'(res_neuron), 64'd5);
      check("emit_in_ready", 64'(in_ready), 64'd0);
      check("emit_time_val", 64'(layer_time_val), 64'd0);
      in_valid       = 1'b1;
      in_spike_times = spikes_a;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    check("emit_done_in_ready", 64'(in_ready), 64'd1);
    check("emit_done_res_valid", 64'(res_valid), 64'd0);
    check("emit_spikes_held", 64'(layer_spike_times), 64'(spikes_b));
    check("emit_count", 64'(sample_count), 64'd2);

    // Back-to-back train samples with in_valid held high
    in_train       = 1'b1;
    in_spike_times = spikes_a;
    in_valid       = 1'b1;
    n_acc          = 0;
    for (int i = 0; i < 200 && n_acc < 3; i++) begin
      if (in_ready) begin
        acc[n_acc] = cyc;
        n_acc++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("b2b_accepts", 64'(n_acc), 64'd3);
    check("b2b_gap_1", 64'(acc[1] - acc[0]), 64'd25);
    check("b2b_gap_2", 64'(acc[2] - acc[1]), 64'd25);
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("b2b_idle", 64'(in_ready), 64'd1);
    check("b2b_sample_count", 64'(sample_count), 64'd5);

    // Reset at step 4 of a test window discards the result
    model_winner = NW'(11);
    offer(1'b0, spikes_b);
    check_window(4, spikes_b, 1'b0);
    check("mid_step4", 64'(layer_time_val), 64'd4);
    rst_l = 1'b0;
    #1;
    check("mid_rst_res_valid", 64'(res_valid), 64'd0);
    check("mid_rst_time_val", 64'(layer_time_val), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_count", 64'(sample_count), 64'd0);
    check("mid_rst_spikes", 64'(layer_spike_times), 64'd0);
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);

    // Next sample runs a full window from step 0
    model_winner = NW'(9);
    exp_q.push_back('{neuron: NW'(9), count: 16'd1});
    offer(1'b0, spikes_a);
    check_window(TSP, spikes_a, 1'b0);
    check("after_rst_res_valid", 64'(res_valid), 64'd1);
    @(negedge clk);
    check("after_rst_idle", 64'(in_ready), 64'd1);

    // Wrap: preload 65535 completions, one more test sample returns the count to 0
    force dut.sample_cnt_q = 16'hffff;
    @(negedge clk);
    release dut.sample_cnt_q;
    check("wrap_preload", 64'(sample_count), 64'hffff);
    model_winner = NW'(3);
    exp_q.push_back('{neuron: NW'(3), count: 16'd0});
    offer(1'b0, spikes_b);
    check_window(TSP, spikes_b, 1'b0);
    @(negedge clk);
    check("wrap_count", 64'(sample_count), 64'd0);
    check("wrap_idle", 64'(in_ready), 64'd1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
